// File: rtl/sel_input_scan.sv
// sel_input_scan
//   Automatic channel-scan sequencer that drives the input-mux selector's
//   register-write port. For each channel it writes {en=1, ch}, waits for the
//   selector to report active, lets the mux settle, requests one ADC
//   acquisition, then moves on. Channels run first_ch..last_ch and wrap past
//   CH_MAX. At the end of the scan it writes zero to disable the mux, waits for
//   the selector to go idle, and then pulses done.
//
// Ports
//   clk        system clock
//   rst_       asynchronous active-low reset
//   start      1-clk pulse: begin a scan (ignored while busy)
//   stop       1-clk pulse: abort the scan
//   first_ch   first channel, sampled on an accepted start
//   last_ch    last channel, sampled on an accepted start
//   sel_active selector "channel active" status
//   acq_done   ADC acquisition complete (1-clk pulse)
//   sel_wr     1-clk write strobe to the selector
//   sel_data   selector write data {23'b0, en, ch[7:0]}
//   acq_req    1-clk acquisition request to the ADC
//   cur_ch     channel currently selected
//   busy       high in every state except idle
//   done       1-clk pulse: scan completed normally
//   err        sticky: selector timeout or out-of-range start; cleared by an
//              accepted start
module sel_input_scan #(
  parameter int CH_W   = 8,
  parameter int CH_MAX = 156,
  parameter int SETTLE = 50,
  parameter int TMO    = 1024
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            start,
  input  logic            stop,
  input  logic [CH_W-1:0] first_ch,
  input  logic [CH_W-1:0] last_ch,
  input  logic            sel_active,
  input  logic            acq_done,
  output logic            sel_wr,
  output logic [31:0]     sel_data,
  output logic            acq_req,
  output logic [CH_W-1:0] cur_ch,
  output logic            busy,
  output logic            done,
  output logic            err
);

  // One timer serves both the selector timeout and the settle delay. It only
  // ever counts up to (limit - 1), so clog2 of the larger limit is enough.
  localparam int TMR_MAX = (TMO > SETTLE) ? TMO : SETTLE;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(TMO - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [CH_W-1:0]  CH_LIMIT    = CH_W'(CH_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ON,
    S_WAIT_ON,
    S_SETTLE,
    S_ACQ,
    S_NEXT,
    S_WR_OFF,
    S_WAIT_OFF
  } state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic              err_q, err_d;
  // Set whenever the scan is being torn down early (stop or timeout), so the
  // final return to idle does not report a normal completion.
  logic              abort_q, abort_d;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      cur_ch_q <= '0;
      last_q   <= '0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cur_ch_q <= cur_ch_d;
      last_q   <= last_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cur_ch_d = cur_ch_q;
    last_d   = last_q;
    err_d    = err_q;
    abort_d  = abort_q;
    sel_wr   = 1'b0;
    sel_data = '0;
    acq_req  = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // stop wins over a simultaneous start.
        if (start && !stop) begin
          if ((first_ch > CH_LIMIT) || (last_ch > CH_LIMIT)) begin
            err_d = 1'b1;
          end else begin
            cur_ch_d = first_ch;
            last_d   = last_ch;
            err_d    = 1'b0;
            abort_d  = 1'b0;
            state_d  = S_WR_ON;
          end
        end
      end

      S_WR_ON: begin
        sel_wr   = 1'b1;
        sel_data = {{(31 - CH_W){1'b0}}, 1'b1, cur_ch_q};
        timer_d  = '0;
        // A stop here is remembered and acted on in the next state, so that
        // the off-write never follows this write on the very next clock.
        if (stop) begin
          abort_d = 1'b1;
        end
        state_d = S_WAIT_ON;
      end

      S_WAIT_ON: begin
        if (stop || abort_q) begin
          abort_d = 1'b1;
          state_d = S_WR_OFF;
        end else if (sel_active) begin
          timer_d = '0;
          state_d = S_SETTLE;
        end else if (timer_q == TMO_LAST) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = S_WR_OFF;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_SETTLE: begin
        if (stop) begin
          abort_d = 1'b1;
          state_d = S_WR_OFF;
        end else if (timer_q == SETTLE_LAST) begin
          acq_req = 1'b1;
          state_d = S_ACQ;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_ACQ: begin
        if (stop) begin
          abort_d = 1'b1;
          state_d = S_WR_OFF;
        end else if (acq_done) begin
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        if (stop) begin
          abort_d = 1'b1;
          state_d = S_WR_OFF;
        end else if (cur_ch_q == last_q) begin
          state_d = S_WR_OFF;
        end else begin
          cur_ch_d = (cur_ch_q == CH_LIMIT) ? '0 : cur_ch_q + CH_W'(1);
          state_d  = S_WR_ON;
        end
      end

      S_WR_OFF: begin
        sel_wr   = 1'b1;
        sel_data = '0;
        state_d  = S_WAIT_OFF;
      end

      S_WAIT_OFF: begin
        // The selector holds active through its post-off guard time.
        if (!sel_active) begin
          done    = !abort_q;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign cur_ch = cur_ch_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sel_input_scan.sv
// tb_sel_input_scan
//   Directed bench for sel_input_scan. A small selector/ADC responder raises
//   sel_active 2 clocks after an enabling write, drops it on any write, and
//   pulses acq_done 10 clocks after acq_req. A monitor logs every write and
//   acquisition so each scan can be compared against hand-computed values.
module tb_sel_input_scan;

  localparam int SETTLE = 50;
  localparam int TMO    = 1024;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  first_ch = '0;
  logic [7:0]  last_ch = '0;
  logic        sel_active = 1'b0;
  logic        acq_done = 1'b0;
  logic        sel_wr;
  logic [31:0] sel_data;
  logic        acq_req;
  logic [7:0]  cur_ch;
  logic        busy;
  logic        done;
  logic        err;

  sel_input_scan #(
    .CH_W   (8),
    .CH_MAX (156),
    .SETTLE (SETTLE),
    .TMO    (TMO)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .start      (start),
    .stop       (stop),
    .first_ch   (first_ch),
    .last_ch    (last_ch),
    .sel_active (sel_active),
    .acq_done   (acq_done),
    .sel_wr     (sel_wr),
    .sel_data   (sel_data),
    .acq_req    (acq_req),
    .cur_ch     (cur_ch),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] wr_q[$];
  int          wr_cyc_q[$];
  int          gap_q[$];
  int          acq_n = 0;
  int          done_n = 0;
  int          overlap_n = 0;
  int          consec_n = 0;
  int          err_cyc = 0;
  int          rise_cyc = 0;
  int          act_cnt = 0;
  int          acq_cnt = 0;
  logic        prev_wr = 1'b0;
  logic        prev_err = 1'b0;
  bit          resp_en = 1'b1;

  int base_wr, base_acq, base_gap, base_done;

  always @(posedge clk) cyc++;

  // Monitor first (outputs are stable mid-cycle), then the responder model.
  always @(negedge clk) begin
    if (!rst_) begin
      sel_active = 1'b0;
      acq_done   = 1'b0;
      act_cnt    = 0;
      acq_cnt    = 0;
      prev_wr    = 1'b0;
      prev_err   = 1'b0;
    end else begin
      if (sel_wr) begin
        wr_q.push_back(sel_data);
        wr_cyc_q.push_back(cyc);
      end
      if (sel_wr && prev_wr) consec_n++;
      if (sel_wr && acq_req) overlap_n++;
      if (acq_req) begin
        acq_n++;
        gap_q.push_back(cyc - rise_cyc);
      end
      if (done) done_n++;
      if (err && !prev_err) err_cyc = cyc;
      prev_wr  = sel_wr;
      prev_err = err;

      acq_done = 1'b0;
      if (sel_wr) begin
        sel_active = 1'b0;
        act_cnt    = (sel_data[8] && resp_en) ? 2 : 0;
      end else if (act_cnt > 0) begin
        act_cnt--;
        if (act_cnt == 0) begin
          sel_active = 1'b1;
          rise_cyc   = cyc;
        end
      end
      if (acq_req) begin
        acq_cnt = 10;
      end else if (acq_cnt > 0) begin
        acq_cnt--;
        if (acq_cnt == 0) acq_done = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one start pulse (optionally with stop) and returns on the
  // following negedge, where the first write of an accepted start is visible.
  task automatic applyStimulus(input logic [7:0] f, input logic [7:0] l, input logic s);
    first_ch = f;
    last_ch  = l;
    start    = 1'b1;
    stop     = s;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic snap();
    base_wr   = wr_q.size();
    base_acq  = acq_n;
    base_gap  = gap_q.size();
    base_done = done_n;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " idle"}, {31'b0, busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic checkWrites(input string tag, input logic [31:0] exp_q[$]);
    checkOutput({tag, " wr count"}, wr_q.size() - base_wr, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base_wr + i < wr_q.size())
        checkOutput($sformatf("%s wr%0d", tag, i), wr_q[base_wr + i], exp_q[i]);
    end
  endtask

  task automatic checkScan(input string tag, input int exp_acq, input int exp_done);
    checkOutput({tag, " acq count"}, acq_n - base_acq, exp_acq);
    checkOutput({tag, " done count"}, done_n - base_done, exp_done);
    for (int i = base_gap; i < gap_q.size(); i++)
      checkOutput($sformatf("%s settle gap%0d", tag, i - base_gap), gap_q[i], SETTLE);
  endtask

  initial begin
    logic [31:0] exp_q[$];
    int n;

    // Reset values while rst_ is held low.
    repeat (3) @(negedge clk);
    checkOutput("rst busy", {31'b0, busy}, 32'd0);
    checkOutput("rst sel_wr", {31'b0, sel_wr}, 32'd0);
    checkOutput("rst sel_data", sel_data, 32'd0);
    checkOutput("rst acq_req", {31'b0, acq_req}, 32'd0);
    checkOutput("rst done", {31'b0, done}, 32'd0);
    checkOutput("rst err", {31'b0, err}, 32'd0);
    checkOutput("rst cur_ch", {24'b0, cur_ch}, 32'd0);
    rst_ = 1'b1;
    repeat (2) @(negedge clk);

    // 1: plain scan 3..5.
    $display("[TB] scan 3..5");
    snap();
    applyStimulus(8'd3, 8'd5, 1'b0);
    checkOutput("t1 first wr", {31'b0, sel_wr}, 32'd1);
    checkOutput("t1 first data", sel_data, 32'h103);
    checkOutput("t1 busy", {31'b0, busy}, 32'd1);
    waitIdle("t1", 2000);
    exp_q = {32'h103, 32'h104, 32'h105, 32'h000};
    checkWrites("t1", exp_q);
    checkScan("t1", 3, 1);
    checkOutput("t1 cur_ch", {24'b0, cur_ch}, 32'd5);
    checkOutput("t1 err", {31'b0, err}, 32'd0);

    // 2: wrapping scan 155..1, with a start while busy that must be ignored.
    $display("[TB] scan 155..1");
    snap();
    applyStimulus(8'd155, 8'd1, 1'b0);
    checkOutput("t2 first data", sel_data, 32'h19B);
    repeat (5) @(negedge clk);
    applyStimulus(8'd50, 8'd60, 1'b0);
    waitIdle("t2", 2000);
    exp_q = {32'h19B, 32'h19C, 32'h100, 32'h101, 32'h000};
    checkWrites("t2", exp_q);
    checkScan("t2", 4, 1);
    checkOutput("t2 cur_ch", {24'b0, cur_ch}, 32'd1);

    // 3: selector never reports active -> timeout.
    $display("[TB] selector timeout");
    resp_en = 1'b0;
    snap();
    applyStimulus(8'd7, 8'd9, 1'b0);
    waitIdle("t3", 3000);
    exp_q = {32'h107, 32'h000};
    checkWrites("t3", exp_q);
    checkScan("t3", 0, 0);
    checkOutput("t3 err", {31'b0, err}, 32'd1);
    if (wr_q.size() > base_wr)
      checkOutput("t3 err timing", err_cyc - wr_cyc_q[base_wr], TMO + 1);
    resp_en = 1'b1;

    // 4: stop during the settle of channel 4 in a 3..8 scan.
    $display("[TB] stop during settle");
    snap();
    applyStimulus(8'd3, 8'd8, 1'b0);
    n = 0;
    while (!(sel_active && (wr_q.size() - base_wr == 2)) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t4 reach ch4", {31'b0, (n < 500)}, 32'd1);
    repeat (10) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checkOutput("t4 off wr", {31'b0, sel_wr}, 32'd1);
    checkOutput("t4 off data", sel_data, 32'h000);
    waitIdle("t4", 200);
    exp_q = {32'h103, 32'h104, 32'h000};
    checkWrites("t4", exp_q);
    checkScan("t4", 1, 0);
    checkOutput("t4 err", {31'b0, err}, 32'd0);

    // 5: out-of-range start, start+stop together, then a valid start.
    $display("[TB] out-of-range start");
    snap();
    applyStimulus(8'd0, 8'd200, 1'b0);
    checkOutput("t5 err set", {31'b0, err}, 32'd1);
    checkOutput("t5 busy", {31'b0, busy}, 32'd0);
    checkOutput("t5 no wr", {31'b0, sel_wr}, 32'd0);
    applyStimulus(8'd10, 8'd10, 1'b1);
    checkOutput("t5 stop wins busy", {31'b0, busy}, 32'd0);
    checkOutput("t5 stop wins err", {31'b0, err}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("t5 wr none", wr_q.size() - base_wr, 32'd0);
    applyStimulus(8'd10, 8'd10, 1'b0);
    checkOutput("t5 err cleared", {31'b0, err}, 32'd0);
    checkOutput("t5 wr", {31'b0, sel_wr}, 32'd1);
    checkOutput("t5 data", sel_data, 32'h10A);
    waitIdle("t5", 500);
    exp_q = {32'h10A, 32'h000};
    checkWrites("t5", exp_q);
    checkScan("t5", 1, 1);

    // 6: asynchronous reset during acquisition.
    $display("[TB] reset during acquisition");
    snap();
    applyStimulus(8'd20, 8'd22, 1'b0);
    n = 0;
    while (acq_n == base_acq && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6 reach acq", {31'b0, (n < 500)}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("t6 cur_ch pre", {24'b0, cur_ch}, 32'd20);
    #2 rst_ = 1'b0;
    #1;
    checkOutput("t6 busy", {31'b0, busy}, 32'd0);
    checkOutput("t6 sel_wr", {31'b0, sel_wr}, 32'd0);
    checkOutput("t6 sel_data", sel_data, 32'd0);
    checkOutput("t6 acq_req", {31'b0, acq_req}, 32'd0);
    checkOutput("t6 done", {31'b0, done}, 32'd0);
    checkOutput("t6 cur_ch", {24'b0, cur_ch}, 32'd0);
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    snap();
    applyStimulus(8'd20, 8'd20, 1'b0);
    checkOutput("t6 restart data", sel_data, 32'h114);
    waitIdle("t6", 500);
    exp_q = {32'h114, 32'h000};
    checkWrites("t6", exp_q);
    checkScan("t6", 1, 1);

    // Invariants over the whole run.
    checkOutput("wr+acq overlap", overlap_n, 32'd0);
    checkOutput("consecutive wr", consec_n, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
